// File: rtl/chess_move_controller_if.sv
// chess_move_controller_if: single read/write port of the 64-square board layout memory.
//   SqAddr   [5:0]  square index Y*8+X, driven by the controller
//   SqWrEn          write strobe, driven by the controller
//   SqWrData [7:0]  write data, driven by the controller
//   SqRdData [7:0]  read data from the memory, valid one cycle after SqAddr
//   modport master: controller side; modport slave: memory side
interface chess_move_controller_if;
  logic [5:0] SqAddr;
  logic       SqWrEn;
  logic [7:0] SqWrData;
  logic [7:0] SqRdData;
  modport master(output SqAddr, SqWrEn, SqWrData, input SqRdData);
  modport slave(input SqAddr, SqWrEn, SqWrData, output SqRdData);
endinterface

// File: rtl/chess_move_controller.sv
// chess_move_controller: sequences one player move on the board layout memory
// (cursor, pick-up, destination check, two-write commit, turn hand-over, timeouts).
//   clock, resetApp_n           clock and asynchronous active-low reset
//   Tick                        key-sample strobe; keys act only when it is high
//   KeyLeft/Right/Up/Down/Select active-low keys, priority in that order
//   TimeoutWhite/TimeoutBlack   level timeout flags from the game timer
//   sq                          layout memory port (master side)
//   CursorX/CursorY             cursor column/row
//   Selected, SrcIdx            a source piece is held, and where
//   Turn                        side to move (0 white, 1 black)
//   MoveDone                    one-cycle pulse per committed move
//   GameOver, Winner            sticky end-of-game flag and winning colour
// Build option CAPTURE_COUNT_EN adds CapturedByWhite/CapturedByBlack saturating counters.
module chess_move_controller #(
  parameter int         CHESS_SQUARES = 64,
  parameter int         SQUARE_WIDTH  = 8,
  parameter logic [2:0] CURSOR_INIT_X = 3'd2,
  parameter logic [2:0] CURSOR_INIT_Y = 3'd3
) (
  input  logic clock,
  input  logic resetApp_n,
  input  logic Tick,
  input  logic KeyLeft,
  input  logic KeyRight,
  input  logic KeyUp,
  input  logic KeyDown,
  input  logic KeySelect,
  input  logic TimeoutWhite,
  input  logic TimeoutBlack,
  chess_move_controller_if.master sq,
  output logic [2:0] CursorX,
  output logic [2:0] CursorY,
  output logic Selected,
  output logic [$clog2(CHESS_SQUARES)-1:0] SrcIdx,
  output logic Turn,
  output logic MoveDone,
  output logic GameOver,
  output logic Winner
`ifdef CAPTURE_COUNT_EN
  ,
  output logic [3:0] CapturedByWhite,
  output logic [3:0] CapturedByBlack
`endif
);
  typedef enum logic [3:0] {
    WAIT_SRC, RD_SRC, CHK_SRC, WAIT_DST, RD_DST, CHK_DST, WR_DST, WR_SRC, DONE, GAME_OVER
  } state_t;
  state_t state, stateNext;
  logic [2:0] cursorXNext, cursorYNext;
  logic [5:0] sqAddr, sqAddrNext, cursorIdx, srcIdxNext;
  logic [SQUARE_WIDTH-1:0] srcByte, srcByteNext;
  logic [3:0] dstHi, dstHiNext;
  logic selectedNext, turnNext, gameOverNext, winnerNext;
  logic inWait, goLeft, goRight, goUp, goDown, goSelect, ownPiece;
  assign cursorIdx = {CursorY, CursorX};
  assign inWait    = state == WAIT_SRC || state == WAIT_DST;
  assign goLeft    = Tick && !KeyLeft;
  assign goRight   = Tick && KeyLeft && !KeyRight;
  assign goUp      = Tick && KeyLeft && KeyRight && !KeyUp;
  assign goDown    = Tick && KeyLeft && KeyRight && KeyUp && !KeyDown;
  assign goSelect  = Tick && KeyLeft && KeyRight && KeyUp && KeyDown && !KeySelect;
  assign ownPiece  = sq.SqRdData[3:0] != 4'h0 && sq.SqRdData[3] == Turn;
  assign sq.SqAddr   = sqAddr;
  assign sq.SqWrEn   = state == WR_DST || state == WR_SRC;
  assign sq.SqWrData = state == WR_DST ? {dstHi, srcByte[3:0]} :
                       state == WR_SRC ? {srcByte[SQUARE_WIDTH-1:4], 4'h0} : '0;
  assign MoveDone    = state == DONE;
  always_comb begin
    stateNext    = state;
    cursorXNext  = CursorX;
    cursorYNext  = CursorY;
    selectedNext = Selected;
    srcIdxNext   = SrcIdx;
    srcByteNext  = srcByte;
    dstHiNext    = dstHi;
    turnNext     = Turn;
    gameOverNext = GameOver;
    winnerNext   = Winner;
    // Timeouts are only honoured between moves so a started commit always finishes.
    if (inWait && (TimeoutWhite || TimeoutBlack)) begin
      stateNext    = GAME_OVER;
      gameOverNext = 1'b1;
      selectedNext = 1'b0;
      winnerNext   = (TimeoutWhite && TimeoutBlack) ? ~Turn : TimeoutWhite;
    end else begin
      if (inWait) begin
        cursorXNext = CursorX + {2'b0, goRight} - {2'b0, goLeft};
        cursorYNext = CursorY + {2'b0, goUp} - {2'b0, goDown};
      end
      case (state)
        WAIT_SRC: stateNext = goSelect ? RD_SRC : WAIT_SRC;
        RD_SRC:   stateNext = CHK_SRC;
        CHK_SRC: begin
          stateNext = ownPiece ? WAIT_DST : WAIT_SRC;
          if (ownPiece) begin
            srcByteNext  = sq.SqRdData;
            srcIdxNext   = cursorIdx;
            selectedNext = 1'b1;
          end
        end
        WAIT_DST: if (goSelect) begin
          stateNext    = cursorIdx == SrcIdx ? WAIT_SRC : RD_DST;
          selectedNext = cursorIdx != SrcIdx;
        end
        RD_DST:   stateNext = CHK_DST;
        CHK_DST: begin
          stateNext = ownPiece ? WAIT_DST : WR_DST;
          if (ownPiece) begin
            srcByteNext = sq.SqRdData;
            srcIdxNext  = cursorIdx;
          end else dstHiNext = sq.SqRdData[7:4];
        end
        WR_DST:    stateNext = WR_SRC;
        WR_SRC:    stateNext = DONE;
        DONE: begin
          stateNext    = WAIT_SRC;
          turnNext     = ~Turn;
          selectedNext = 1'b0;
        end
        GAME_OVER: stateNext = GAME_OVER;
        default:   stateNext = WAIT_SRC;
      endcase
    end
    // The cursor stays on the destination through WR_DST, so only WR_SRC needs a redirect.
    sqAddrNext = stateNext == WR_SRC ? SrcIdx : {cursorYNext, cursorXNext};
  end
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state    <= WAIT_SRC;
      CursorX  <= CURSOR_INIT_X;
      CursorY  <= CURSOR_INIT_Y;
      sqAddr   <= '0;
      Selected <= 1'b0;
      SrcIdx   <= '0;
      srcByte  <= '0;
      dstHi    <= '0;
      Turn     <= 1'b0;
      GameOver <= 1'b0;
      Winner   <= 1'b0;
    end else begin
      state    <= stateNext;
      CursorX  <= cursorXNext;
      CursorY  <= cursorYNext;
      sqAddr   <= sqAddrNext;
      Selected <= selectedNext;
      SrcIdx   <= srcIdxNext;
      srcByte  <= srcByteNext;
      dstHi    <= dstHiNext;
      Turn     <= turnNext;
      GameOver <= gameOverNext;
      Winner   <= winnerNext;
    end
  end
`ifdef CAPTURE_COUNT_EN
  logic captured;
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      captured        <= 1'b0;
      CapturedByWhite <= '0;
      CapturedByBlack <= '0;
    end else begin
      if (state == CHK_DST) captured <= sq.SqRdData[3:0] != 4'h0;
      if (state == DONE && captured && !Turn && CapturedByWhite != 4'hF)
        CapturedByWhite <= CapturedByWhite + 4'h1;
      if (state == DONE && captured && Turn && CapturedByBlack != 4'hF)
        CapturedByBlack <= CapturedByBlack + 4'h1;
    end
  end
`endif
endmodule

// File: tb/tb_chess_move_controller.sv
// tb_chess_move_controller: randomized and directed bench for chess_move_controller,
// checked against a move-level reference model of the board and game state.
module tb_chess_move_controller;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic resetApp_n, Tick, KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect, TimeoutWhite, TimeoutBlack;
  logic [2:0] CursorX, CursorY;
  logic [5:0] SrcIdx;
  logic Selected, Turn, MoveDone, GameOver, Winner;
`ifdef CAPTURE_COUNT_EN
  logic [3:0] CapturedByWhite, CapturedByBlack;
`endif
  chess_move_controller_if sqBus();
  chess_move_controller dut (
    .clock(clock), .resetApp_n(resetApp_n), .Tick(Tick),
    .KeyLeft(KeyLeft), .KeyRight(KeyRight), .KeyUp(KeyUp), .KeyDown(KeyDown), .KeySelect(KeySelect),
    .TimeoutWhite(TimeoutWhite), .TimeoutBlack(TimeoutBlack), .sq(sqBus),
    .CursorX(CursorX), .CursorY(CursorY), .Selected(Selected), .SrcIdx(SrcIdx), .Turn(Turn),
    .MoveDone(MoveDone), .GameOver(GameOver), .Winner(Winner)
`ifdef CAPTURE_COUNT_EN
    , .CapturedByWhite(CapturedByWhite), .CapturedByBlack(CapturedByBlack)
`endif
  );
  localparam logic [4:0] K_LEFT = 5'h1e, K_RIGHT = 5'h1d, K_UP = 5'h1b, K_DOWN = 5'h17, K_SEL = 5'h0f;
  // Layout memory: one-cycle read latency, loadable image while in reset.
  logic [7:0] mem [64];
  logic [7:0] loadImage [64];
  logic loadEn = 1'b0;
  always @(posedge clock) begin
    if (loadEn) mem <= loadImage;
    else if (sqBus.SqWrEn) mem[sqBus.SqAddr] <= sqBus.SqWrData;
    sqBus.SqRdData <= mem[sqBus.SqAddr];
  end
  // Monitor: counts MoveDone cycles and logs every write with its cycle number.
  int cycle = 0, doneCount = 0, wrCount = 0;
  logic [5:0] wrAddrLog [1024];
  logic [7:0] wrDataLog [1024];
  int wrCycleLog [1024];
  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (resetApp_n) begin
      if (MoveDone) doneCount <= doneCount + 1;
      if (sqBus.SqWrEn) begin
        wrAddrLog[wrCount % 1024]  <= sqBus.SqAddr;
        wrDataLog[wrCount % 1024]  <= sqBus.SqWrData;
        wrCycleLog[wrCount % 1024] <= cycle;
        wrCount <= wrCount + 1;
      end
    end
  end
  int checks = 0, errors = 0;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference model: game state as seen by the players, one key action at a time.
  logic [7:0] refMem [64];
  int cx, cy, refSrc, refMoves, capW, capB, baseDone, baseWr;
  logic refSel, refTurn, refOver, refWinner;
  task automatic refStep(input logic [4:0] k);
    int idx;
    logic [3:0] p;
    logic own;
    if (refOver) return;
    if (!k[0]) cx = (cx + 7) % 8;
    else if (!k[1]) cx = (cx + 1) % 8;
    else if (!k[2]) cy = (cy + 1) % 8;
    else if (!k[3]) cy = (cy + 7) % 8;
    else if (!k[4]) begin
      idx = cy * 8 + cx;
      p = refMem[idx][3:0];
      own = p != 4'h0 && p[3] == refTurn;
      if (!refSel) begin
        if (own) begin refSel = 1'b1; refSrc = idx; end
      end else if (idx == refSrc) refSel = 1'b0;
      else if (own) refSrc = idx;
      else begin
        if (p != 4'h0) begin
          if (refTurn) capB = capB < 15 ? capB + 1 : 15;
          else capW = capW < 15 ? capW + 1 : 15;
        end
        refMem[idx] = {refMem[idx][7:4], refMem[refSrc][3:0]};
        refMem[refSrc][3:0] = 4'h0;
        refTurn = ~refTurn;
        refSel = 1'b0;
        refMoves++;
      end
    end
  endtask
  task automatic refTimeout(input logic w, input logic b);
    if (!refOver && (w || b)) begin
      refOver = 1'b1;
      refSel = 1'b0;
      refWinner = (w && b) ? ~refTurn : w;
    end
  endtask
  task automatic setKeys(input logic [4:0] k);
    {KeySelect, KeyDown, KeyUp, KeyRight, KeyLeft} = k;
  endtask
  task automatic clearBoard();
    for (int i = 0; i < 64; i++) refMem[i] = 8'h00;
  endtask
  task automatic randomBoard();
    logic [3:0] p;
    for (int i = 0; i < 64; i++) begin
      p = $urandom_range(0, 2) == 0 ? 4'h0 : {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
      refMem[i] = {4'($urandom_range(0, 15)), p};
    end
  endtask
  // Loads refMem into the layout memory under reset and restarts the model.
  task automatic resetBoard();
    loadImage = refMem;
    resetApp_n = 1'b0; loadEn = 1'b1; Tick = 1'b0; setKeys(5'h1f);
    TimeoutWhite = 1'b0; TimeoutBlack = 1'b0;
    @(negedge clock); @(negedge clock);
    loadEn = 1'b0;
    cx = 2; cy = 3; refSel = 1'b0; refSrc = 0; refTurn = 1'b0; refOver = 1'b0; refWinner = 1'b0;
    refMoves = 0; capW = 0; capB = 0;
    baseDone = doneCount; baseWr = wrCount;
    resetApp_n = 1'b1;
    @(negedge clock);
  endtask
  // One Tick with the given keys, then idle cycles with Tick low and noisy keys.
  task automatic pressTick(input logic [4:0] k);
    setKeys(k); Tick = 1'b1;
    @(negedge clock);
    Tick = 1'b0;
    for (int i = 0; i < 7; i++) begin setKeys(5'($urandom)); @(negedge clock); end
    setKeys(5'h1f);
    refStep(k);
  endtask
  // Select on the current square and stop in the cycle where the destination write is on the bus.
  task automatic selectToWrDst();
    setKeys(K_SEL); Tick = 1'b1;
    @(negedge clock);
    Tick = 1'b0; setKeys(5'h1f);
    @(negedge clock); @(negedge clock);
  endtask
  task automatic timeoutNow(input logic w, input logic b);
    TimeoutWhite = w; TimeoutBlack = b;
    @(negedge clock); @(negedge clock);
    refTimeout(w, b);
  endtask
  task automatic compareState(input string tag);
    checkVal({tag, ".cursorX"}, CursorX, cx);
    checkVal({tag, ".cursorY"}, CursorY, cy);
    checkVal({tag, ".sqAddr"}, sqBus.SqAddr, cy * 8 + cx);
    checkVal({tag, ".selected"}, Selected, refSel);
    checkVal({tag, ".turn"}, Turn, refTurn);
    checkVal({tag, ".gameOver"}, GameOver, refOver);
    checkVal({tag, ".moves"}, doneCount - baseDone, refMoves);
    checkVal({tag, ".writes"}, wrCount - baseWr, 2 * refMoves);
    if (refSel) checkVal({tag, ".srcIdx"}, SrcIdx, refSrc);
    if (refOver) checkVal({tag, ".winner"}, Winner, refWinner);
`ifdef CAPTURE_COUNT_EN
    checkVal({tag, ".capW"}, CapturedByWhite, capW);
    checkVal({tag, ".capB"}, CapturedByBlack, capB);
`endif
  endtask
  task automatic compareBoard(input string tag);
    for (int i = 0; i < 64; i++) checkVal($sformatf("%s.sq%0d", tag, i), mem[i], refMem[i]);
  endtask
  // Cursor from reset (2,3) to square 12 (4,1), pick up, then step up to square 20.
  task automatic pickUp12Goto20();
    pressTick(K_RIGHT); pressTick(K_RIGHT); pressTick(K_DOWN); pressTick(K_DOWN);
    pressTick(K_SEL);
    pressTick(K_UP);
  endtask
  initial begin
    int wb;
    logic [4:0] k;
    logic w, b;
    resetApp_n = 1'b0; Tick = 1'b0; setKeys(5'h1f); TimeoutWhite = 1'b0; TimeoutBlack = 1'b0;
    @(negedge clock); @(negedge clock);
    checkVal("rst.cursorX", CursorX, 2);
    checkVal("rst.cursorY", CursorY, 3);
    checkVal("rst.sqAddr", sqBus.SqAddr, 0);
    checkVal("rst.wrEn", sqBus.SqWrEn, 0);
    checkVal("rst.wrData", sqBus.SqWrData, 0);
    checkVal("rst.selected", Selected, 0);
    checkVal("rst.srcIdx", SrcIdx, 0);
    checkVal("rst.turn", Turn, 0);
    checkVal("rst.moveDone", MoveDone, 0);
    checkVal("rst.gameOver", GameOver, 0);
    checkVal("rst.winner", Winner, 0);
    // Cursor wrap along X
    clearBoard(); resetBoard();
    repeat (3) pressTick(K_RIGHT);
    checkVal("right3.cursorX", CursorX, 5);
    repeat (3) pressTick(K_RIGHT);
    checkVal("wrap.cursorX", CursorX, 0);
    checkVal("wrap.cursorY", CursorY, 3);
    compareState("wrap");
    // Plain move 12 -> 20 with write order and timing
    clearBoard(); refMem[12] = 8'h01; resetBoard();
    pickUp12Goto20();
    checkVal("move.held", Selected, 1);
    wb = wrCount;
    pressTick(K_SEL);
    checkVal("move.wr0.addr", wrAddrLog[wb % 1024], 20);
    checkVal("move.wr0.data", wrDataLog[wb % 1024], 8'h01);
    checkVal("move.wr1.addr", wrAddrLog[(wb + 1) % 1024], 12);
    checkVal("move.wr1.data", wrDataLog[(wb + 1) % 1024], 8'h00);
    checkVal("move.wrGap", wrCycleLog[(wb + 1) % 1024] - wrCycleLog[wb % 1024], 1);
    checkVal("move.turn", Turn, 1);
    compareState("move");
    compareBoard("move");
    // Opponent piece under the cursor cannot be picked up
    clearBoard(); refMem[26] = 8'h09; resetBoard();
    pressTick(K_SEL);
    checkVal("black.selected", Selected, 0);
    pressTick(K_LEFT);
    compareState("black");
    // Deselect and re-select onto own piece
    clearBoard(); refMem[12] = 8'h01; refMem[13] = 8'h02; resetBoard();
    pressTick(K_RIGHT); pressTick(K_RIGHT); pressTick(K_DOWN); pressTick(K_DOWN);
    pressTick(K_SEL); pressTick(K_SEL);
    checkVal("desel.selected", Selected, 0);
    pressTick(K_SEL); pressTick(K_RIGHT); pressTick(K_SEL);
    checkVal("resel.srcIdx", SrcIdx, 13);
    checkVal("resel.selected", Selected, 1);
    compareState("resel");
    // Reset asserted during the destination write abandons the move
    clearBoard(); refMem[12] = 8'h01; refMem[20] = 8'h30; resetBoard();
    pickUp12Goto20();
    selectToWrDst();
    checkVal("abort.wrEnBefore", sqBus.SqWrEn, 1);
    resetApp_n = 1'b0;
    #1;
    checkVal("abort.wrEn", sqBus.SqWrEn, 0);
    checkVal("abort.selected", Selected, 0);
    checkVal("abort.cursorX", CursorX, 2);
    @(negedge clock);
    checkVal("abort.sq20", mem[20], 8'h30);
    checkVal("abort.sq12", mem[12], 8'h01);
    // Timeout during the destination write is deferred until the move commits
    clearBoard(); refMem[12] = 8'h01; resetBoard();
    pickUp12Goto20();
    selectToWrDst();
    TimeoutBlack = 1'b1;
    repeat (6) @(negedge clock);
    refStep(K_SEL);
    refTimeout(1'b0, 1'b1);
    checkVal("late.gameOver", GameOver, 1);
    checkVal("late.winner", Winner, 0);
    compareState("late");
    compareBoard("late");
    pressTick(K_RIGHT); pressTick(K_SEL);
    compareState("late.keys");
    // Capture move, then both timeouts with black to move
    clearBoard(); refMem[12] = 8'h01; refMem[20] = 8'h0A; resetBoard();
    pickUp12Goto20();
    pressTick(K_SEL);
`ifdef CAPTURE_COUNT_EN
    checkVal("capture.white", CapturedByWhite, 1);
`endif
    compareState("capture");
    timeoutNow(1'b1, 1'b1);
    checkVal("both.t1.winner", Winner, 0);
    compareState("both.t1");
    clearBoard(); resetBoard();
    timeoutNow(1'b1, 1'b1);
    checkVal("both.t0.winner", Winner, 1);
    // Random games on random boards
    for (int g = 0; g < 4; g++) begin
      randomBoard(); resetBoard();
      for (int s = 0; s < 120; s++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: k = K_SEL;
          9:       k = 5'($urandom);
          default: k = 5'h1f & ~(5'd1 << $urandom_range(0, 3));
        endcase
        pressTick(k);
        compareState($sformatf("rnd%0d.%0d", g, s));
      end
      compareBoard($sformatf("rnd%0d", g));
      w = 1'($urandom_range(0, 1));
      b = w ? 1'($urandom_range(0, 1)) : 1'b1;
      timeoutNow(w, b);
      compareState($sformatf("rnd%0d.to", g));
      pressTick(K_SEL); pressTick(K_LEFT);
      compareState($sformatf("rnd%0d.after", g));
      compareBoard($sformatf("rnd%0d.after", g));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/chess_move_controller.md
Name: chess_move_controller

Overview:
FSM that sequences a complete player move on the 64-square board layout memory: cursor navigation, piece pick-up, destination check, two-write commit (destination, then source), and turn hand-over. It owns the layout's single read/write port and receives per-side timeout flags from the game timer. Square byte format: [7:4] overlay/highlight nibble, preserved by this block. [3:0] piece code: 0 = empty, bit3 = colour (0 white, 1 black), [2:0] = type 1..6.

Parameters:
CHESS_SQUARES, 64, number of board squares (8x8 fixed geometry)
SQUARE_WIDTH, 8, bits per square byte
CURSOR_INIT_X, 2, cursor column after reset (0..7)
CURSOR_INIT_Y, 3, cursor row after reset (0..7)

Ports:
clock  in  1  system clock
resetApp_n  in  1  asynchronous active-low reset
Tick  in  1  one-cycle key-sample strobe from the clock divider
KeyLeft, KeyRight, KeyUp, KeyDown, KeySelect  in  1 each  active-low keys, sampled only when Tick=1
TimeoutWhite, TimeoutBlack  in  1 each  level flags from the game timer
SqRdData  in  8  layout read data, valid one cycle after SqAddr
SqAddr  out  6  layout address (Y*8+X)
SqWrEn  out  1  layout write strobe
SqWrData  out  8  layout write data
CursorX, CursorY  out  3 each  current cursor position
Selected  out  1  a source piece is held
SrcIdx  out  6  held source square
Turn  out  1  side to move (0 white, 1 black)
MoveDone  out  1  one-cycle pulse per committed move
GameOver  out  1  sticky end-of-game flag
Winner  out  1  winning colour, valid when GameOver=1

Behaviour:
- Reset (async, resetApp_n=0): state WAIT_SRC; CursorX/Y = CURSOR_INIT_X/Y; SqAddr=0; SqWrEn=0; SqWrData=0; Selected=0; SrcIdx=0; Turn=0; MoveDone=0; GameOver=0; Winner=0. Reset mid-move abandons the move; no write completes after reset asserts.
- Key decode: one action per Tick. Priority Left > Right > Up > Down > Select. Left/Right: X-1/X+1. Up/Down: Y+1/Y-1. Both wrap mod 8 (7+1 = 0, 0-1 = 7). Cursor moves only in WAIT_SRC and WAIT_DST. Keys are ignored in all other states.
- SqAddr tracks {CursorY,CursorX} in the WAIT states. It is driven explicitly in the write states.
- States:
  - WAIT_SRC: Select tick -> RD_SRC.
  - RD_SRC: one wait cycle for read latency -> CHK_SRC.
  - CHK_SRC: if piece≠0 and bit3==Turn: latch source byte, SrcIdx = cursor, Selected=1, -> WAIT_DST. Otherwise -> WAIT_SRC.
  - WAIT_DST: Select tick on SrcIdx: Selected=0, -> WAIT_SRC (deselect). Select tick elsewhere -> RD_DST.
  - RD_DST -> CHK_DST.
  - CHK_DST: destination holds own colour: re-select it (new SrcIdx and source byte), -> WAIT_DST. Destination empty or opponent: latch destination byte, -> WR_DST.
  - WR_DST: SqWrEn=1, SqAddr=dst, SqWrData={dst[7:4], src[3:0]}.
  - WR_SRC: SqWrEn=1, SqAddr=SrcIdx, SqWrData={src[7:4], 4'h0}.
  - DONE: MoveDone=1 for this cycle only, Turn toggles, Selected=0, -> WAIT_SRC.
  - GAME_OVER: terminal; left only by reset.
- Commit timing: a move commits exactly 3 cycles after CHK_DST (WR_DST, WR_SRC, DONE). SqWrEn is 0 in every other state.
- Timeouts: sampled only in WAIT_SRC and WAIT_DST. A timeout raised mid-sequence is deferred until the sequence returns to a WAIT state, so a started move always completes both writes.
- On timeout: GameOver=1, Winner = colour of the side that did not time out, Selected=0, -> GAME_OVER. If both flags are high together, the side to move loses (Winner = ~Turn).
- No legality checking beyond colour ownership. Piece rules are out of scope.

Optional Feature:
CAPTURE_COUNT_EN. Defined: adds outputs CapturedByWhite[3:0] and CapturedByBlack[3:0], reset to 0. The mover's counter increments in DONE when the latched destination piece was non-zero, saturating at 15. Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, 3 Right ticks -> CursorX 2→5; then 3 more Right ticks -> CursorX wraps 5→0; CursorY stays 3.
- Memory with white pawn 0x01 at idx 12 and empty idx 20: select 12, then select 20 -> idx20 write 0x01, then idx12 write 0x00 on the next cycle, MoveDone pulses once, Turn=1.
- Turn=0 with black piece 0x09 at the cursor: Select -> stays WAIT_SRC, Selected=0, no SqWrEn.
- Holding idx 12: Select idx 12 -> Selected=0. Re-select 12, then Select own piece at idx 13 -> SrcIdx=13, still WAIT_DST, no write.
- TimeoutBlack raised during WR_DST -> both writes complete and MoveDone pulses, then GameOver=1, Winner=0. Keys afterwards change nothing.
- Both timeouts high in WAIT_SRC with Turn=1 -> Winner=0. With CAPTURE_COUNT_EN, white capturing 0x0A -> CapturedByWhite=1.
